// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port / ROB completion path.
// Optional build macro WB_LQ_PRIORITY_EN gives the load queue fixed priority.
module writeback_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int LQ_INDEX = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_reg_write,
    input  logic [NUM_REQ-1:0][5:0]           req_phys_reg_tag,
    input  logic [NUM_REQ-1:0][31:0]          req_data,
    input  logic [NUM_REQ-1:0][4:0]           req_ROB_index,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              flush,
    output logic                              wb_valid,
    output logic                              wb_reg_write,
    output logic [5:0]                        wb_phys_reg_tag,
    output logic [31:0]                       wb_data,
    output logic [4:0]                        wb_ROB_index,
    output logic [$clog2(NUM_REQ)-1:0]        wb_source
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] winner_s;
    logic [IDX_W-1:0] next_ptr_s;
    logic [IDX_W:0]   cand_s;
    logic             found_s;
    logic             prio_s;
    logic             grant_s;

    logic             wb_valid_r;
    logic             wb_reg_write_r;
    logic [5:0]       wb_phys_reg_tag_r;
    logic [31:0]      wb_data_r;
    logic [4:0]       wb_ROB_index_r;
    logic [IDX_W-1:0] wb_source_r;

    // Winner selection: rotating scan from rr_ptr, optional LQ override
    always_comb begin
        found_s  = 1'b0;
        winner_s = {IDX_W{1'b0}};
        prio_s   = 1'b0;
        cand_s   = {(IDX_W+1){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_valid[cand_s[IDX_W-1:0]]) begin
                found_s  = 1'b1;
                winner_s = cand_s[IDX_W-1:0];
            end else begin
                found_s  = found_s;
            end
        end
`ifdef WB_LQ_PRIORITY_EN
        if (req_valid[LQ_INDEX]) begin
            found_s  = 1'b1;
            winner_s = IDX_W'(LQ_INDEX);
            prio_s   = 1'b1;
        end else begin
            prio_s   = 1'b0;
        end
`endif
    end

    // Grant qualification, one-hot ready and pointer advance
    always_comb begin
        grant_s   = found_s && !flush && !RST;
        req_ready = {NUM_REQ{1'b0}};
        if (grant_s) begin
            req_ready = NUM_REQ'(1) << winner_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        if (winner_s == IDX_W'(NUM_REQ - 1)) begin
            next_ptr_s = {IDX_W{1'b0}};
        end else begin
            next_ptr_s = winner_s + IDX_W'(1);
        end
    end

    // Output register and round-robin pointer; payload holds when idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr_r          <= {IDX_W{1'b0}};
            wb_valid_r        <= 1'b0;
            wb_reg_write_r    <= 1'b0;
            wb_phys_reg_tag_r <= 6'd0;
            wb_data_r         <= 32'd0;
            wb_ROB_index_r    <= 5'd0;
            wb_source_r       <= {IDX_W{1'b0}};
        end else if (grant_s) begin
            wb_valid_r        <= 1'b1;
            wb_reg_write_r    <= req_reg_write[winner_s];
            wb_phys_reg_tag_r <= req_phys_reg_tag[winner_s];
            wb_data_r         <= req_data[winner_s];
            wb_ROB_index_r    <= req_ROB_index[winner_s];
            wb_source_r       <= winner_s;
            // Priority grants leave the rotation where it was
            if (!prio_s) begin
                rr_ptr_r <= next_ptr_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end else begin
            wb_valid_r <= 1'b0;
        end
    end

    assign wb_valid        = wb_valid_r;
    assign wb_reg_write    = wb_reg_write_r;
    assign wb_phys_reg_tag = wb_phys_reg_tag_r;
    assign wb_data         = wb_data_r;
    assign wb_ROB_index    = wb_ROB_index_r;
    assign wb_source       = wb_source_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: driver pushes expected writebacks,
// a monitor pops one per cycle and compares against the registered outputs.
module tb_writeback_arbiter;

`ifdef WB_LQ_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef struct {
        logic        vld;
        logic        clr;
        logic [1:0]  src;
        logic        rw;
        logic [5:0]  tag;
        logic [31:0] data;
        logic [4:0]  rob;
    } exp_t;

    logic             CLK;
    logic             RST;
    logic [3:0]       req_valid;
    logic [3:0]       req_reg_write;
    logic [3:0][5:0]  req_phys_reg_tag;
    logic [3:0][31:0] req_data;
    logic [3:0][4:0]  req_ROB_index;
    logic [3:0]       req_ready;
    logic             flush;
    logic             wb_valid;
    logic             wb_reg_write;
    logic [5:0]       wb_phys_reg_tag;
    logic [31:0]      wb_data;
    logic [4:0]       wb_ROB_index;
    logic [1:0]       wb_source;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    writeback_arbiter #(.NUM_REQ(4), .LQ_INDEX(2)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .req_valid        (req_valid),
        .req_reg_write    (req_reg_write),
        .req_phys_reg_tag (req_phys_reg_tag),
        .req_data         (req_data),
        .req_ROB_index    (req_ROB_index),
        .req_ready        (req_ready),
        .flush            (flush),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .wb_phys_reg_tag  (wb_phys_reg_tag),
        .wb_data          (wb_data),
        .wb_ROB_index     (wb_ROB_index),
        .wb_source        (wb_source)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; g is the hand-computed winner, -1 for no grant
    task automatic step(input logic rst, input logic fl, input logic [3:0] vld, input int g);
        exp_t e;
        logic [3:0] exp_rdy;
        @(posedge CLK);
        #2;
        RST       = rst;
        flush     = fl;
        req_valid = vld;
        #2;
        exp_rdy = 4'b0000;
        if (g >= 0) exp_rdy = 4'b0001 << g;
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        e.vld  = (g >= 0);
        e.clr  = rst;
        e.src  = (g >= 0) ? 2'(g) : 2'd0;
        e.rw   = (g >= 0) ? req_reg_write[e.src] : 1'b0;
        e.tag  = (g >= 0) ? req_phys_reg_tag[e.src] : 6'd0;
        e.data = (g >= 0) ? req_data[e.src] : 32'd0;
        e.rob  = (g >= 0) ? req_ROB_index[e.src] : 5'd0;
        exp_q.push_back(e);
    endtask

    // Monitor: compares registered outputs one cycle after each stimulus cycle
    initial begin
        exp_t e;
        exp_t ref_v;
        ref_v = '{vld: 1'b0, clr: 1'b0, src: 2'd0, rw: 1'b0, tag: 6'd0, data: 32'd0, rob: 5'd0};
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.vld) begin
                    ref_v = e;
                end else if (e.clr) begin
                    ref_v = '{vld: 1'b0, clr: 1'b1, src: 2'd0, rw: 1'b0, tag: 6'd0, data: 32'd0, rob: 5'd0};
                end else begin
                    ref_v = ref_v;
                end
                chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.vld});
                chk("wb_source", {30'd0, wb_source}, {30'd0, ref_v.src});
                chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, ref_v.rw});
                chk("wb_phys_reg_tag", {26'd0, wb_phys_reg_tag}, {26'd0, ref_v.tag});
                chk("wb_data", wb_data, ref_v.data);
                chk("wb_ROB_index", {27'd0, wb_ROB_index}, {27'd0, ref_v.rob});
            end else if (wb_valid === 1'b1) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        RST       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'b0000;
        req_reg_write    = 4'b1101;
        req_phys_reg_tag = {6'h04, 6'h33, 6'h22, 6'h11};
        req_data         = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        req_ROB_index    = {5'h04, 5'h03, 5'h02, 5'h01};

        // Reset, then idle
        step(1'b1, 1'b0, 4'b0000, -1);
        step(1'b1, 1'b0, 4'b0000, -1);
        step(1'b0, 1'b0, 4'b0000, -1);

        // All valid: 0,1,2,3,0 (LQ-priority build: always 2)
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 4'b1111, PRIO ? 2 : (k % 4));

        // Single LQ requester with distinctive payload
        req_phys_reg_tag[2] = 6'h2A;
        req_data[2]         = 32'hDEAD_BEEF;
        req_ROB_index[2]    = 5'h13;
        req_reg_write[2]    = 1'b1;
        step(1'b0, 1'b0, 4'b0100, 2);

        // Wrap from pointer 3 to 0, then skip to 1
        step(1'b0, 1'b0, 4'b0011, 0);
        step(1'b0, 1'b0, 4'b0011, 1);

        // Flush kills the grant; next cycle scans 2,3,0 and grants 0
        step(1'b0, 1'b1, 4'b0001, -1);
        step(1'b0, 1'b0, 4'b0001, 0);
        step(1'b0, 1'b0, 4'b0000, -1);

        // Mid-stream reset, then reset together with flush
        step(1'b1, 1'b0, 4'b1111, -1);
        step(1'b1, 1'b1, 4'b1111, -1);

        // From pointer 0: 0,1,2 (priority build: 2,2,2 with pointer held at 0)
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'b1111, PRIO ? 2 : k);
        step(1'b0, 1'b0, 4'b1011, PRIO ? 0 : 3);
        step(1'b0, 1'b0, 4'b0000, -1);

        @(posedge CLK);
        @(posedge CLK);
        #2;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
